opl_write_queue: RTL
====================

Name: opl_write_queue

Overview:
- Upstream stage of the OPL timer/register interface. Buffers sound-CPU writes to the two-port OPL (address port 0, data port 1) in a FIFO.
- Replays the buffered writes downstream as clean write-enable pulses, with enforced recovery gaps after each address and each data write.
- The CPU can write back-to-back without wait states. The downstream interface is edge-triggered on its write strobe, so every write must arrive as a distinct low-high-low pulse.

Parameters:
- DEPTH, 16: FIFO entries. Power of two, minimum 2.
- WE_CYCLES, 2: clk cycles opl_we is held high per write. Minimum 1.
- ADDR_WAIT, 168: clk cycles opl_we stays low after an address-port write. Minimum 1. Default is 2.4 us at 70 MHz.
- DATA_WAIT, 168: clk cycles opl_we stays low after a data-port write. Minimum 1.

Ports:
- clk  in  1  system clock, the same clock the downstream interface uses.
- reset  in  1  synchronous, active-high.
- cpu_cs  in  1  chip select for the OPL window.
- cpu_we  in  1  CPU write strobe (level).
- cpu_addr  in  1  0 = address port, 1 = data port.
- cpu_din  in  8  CPU write data.
- ovf_clr  in  1  clears the overflow flag.
- opl_addr  out  1  port select to the downstream interface.
- opl_din  out  8  data to the downstream interface.
- opl_we  out  1  write strobe to the downstream interface.
- busy  out  1  high when the FIFO is non-empty or the FSM is not IDLE.
- full  out  1  FIFO count == DEPTH.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky flag: a write was dropped.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values:
  - opl_we=0, opl_addr=0, opl_din=0.
  - FIFO empty: level=0, full=0, busy=0.
  - overflow=0, FSM=IDLE, internal edge register=0.
- Reset mid-operation: takes effect at the next edge. opl_we drops that cycle, all queued entries are discarded, the FSM returns to IDLE.
- Write detection:
  - wr = cpu_cs & cpu_we & ~prev, with prev <= cpu_cs & cpu_we registered every cycle.
  - A held strobe yields exactly one push.
- Push:
  - On wr with count < DEPTH: store {cpu_addr, cpu_din} at the write pointer; the pointer wraps modulo DEPTH.
  - On wr with count == DEPTH: the entry is dropped and overflow <= 1. This holds even if a pop occurs in the same cycle; full is evaluated before the pop.
- Overflow flag: ovf_clr clears it. If ovf_clr and a dropped push coincide, the set wins.
- Occupancy: level increments on push and decrements on pop. A simultaneous push and pop leaves level unchanged.
- No empty-FIFO bypass: an entry pushed at edge N is first poppable at edge N+1.
- FSM states:
  - IDLE, when count > 0: pop the head entry, load opl_addr and opl_din, set opl_we <= 1, cnt <= WE_CYCLES-1, go to DRIVE.
  - DRIVE: opl_addr and opl_din are held stable. When cnt == 0: opl_we <= 0, cnt <= (opl_addr ? DATA_WAIT : ADDR_WAIT) - 1, go to WAIT. Otherwise cnt decrements.
  - WAIT: opl_we = 0 and outputs are held. When cnt == 0, go to IDLE; otherwise cnt decrements.
- Latency: CPU strobe sampled high at edge N -> push at edge N -> pop and opl_we high at edge N+1.
- Cadence: for a continuously non-empty FIFO, consecutive opl_we rising edges are WE_CYCLES + WAIT + 1 cycles apart, where WAIT is ADDR_WAIT or DATA_WAIT per the previous entry's port. The +1 is the IDLE cycle.
- Ordering:
  - Strict FIFO order.
  - Address/data pairing is not checked; entries replay exactly as written.
  - opl_addr and opl_din never change while opl_we is high.
- Pointer width: $clog2(DEPTH) bits, plus a separate count register so full and empty are unambiguous.

Test Plan:
Bench parameters: DEPTH=4, WE_CYCLES=2, ADDR_WAIT=4, DATA_WAIT=8.
1. Single pair, push 0x04 then data 0x80: edge timing.
   - Stimulus: push (addr=0, 0x04) at edge 10 and (addr=1, 0x80) at edge 12.
   - Required: opl_we high during edges 11-12 with opl_addr=0, opl_din=0x04.
   - Then low for 4 cycles, IDLE 1 cycle, high again at edge 18 with opl_addr=1, opl_din=0x80.
   - busy falls once the 8-cycle data wait completes.
2. Held strobe: cpu_cs & cpu_we high for 20 cycles -> exactly one push, level peaks at 1, exactly one opl_we pulse.
3. Overflow: 6 one-cycle-apart pushes while the FSM is in its first WAIT.
   - Required: level saturates at 4, full=1, overflow=1, and only the first 4 values replay in order.
   - ovf_clr then clears overflow.
4. Pointer wrap: 10 pairs with data 0x00..0x09 pushed slowly enough never to fill.
   - Required: replay in exact order, level returns to 0, no overflow.
5. Reset mid-DRIVE: assert reset during the first opl_we-high cycle with 3 entries queued.
   - Required: next cycle opl_we=0, level=0, busy=0.
   - No further opl_we pulses until a new push.
6. Simultaneous events: push arrives in the same cycle IDLE pops the last entry -> level stays 1, and the new entry replays after the following wait.

Source files
------------

// File: rtl/opl_write_queue.sv
// OPL write queue: buffers CPU writes to the two-port OPL and replays them
// downstream as distinct write pulses separated by recovery gaps.
module opl_write_queue #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned WE_CYCLES = 2,
    parameter int unsigned ADDR_WAIT = 168,
    parameter int unsigned DATA_WAIT = 168
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cpu_cs,
    input  logic                     cpu_we,
    input  logic                     cpu_addr,
    input  logic [7:0]               cpu_din,
    input  logic                     ovf_clr,
    output logic                     opl_addr,
    output logic [7:0]               opl_din,
    output logic                     opl_we,
    output logic                     busy,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned MaxAw  = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
    localparam int unsigned CntMax = (WE_CYCLES > MaxAw) ? WE_CYCLES : MaxAw;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] WeLoad   = CntW'(WE_CYCLES - 1);
    localparam logic [CntW-1:0] AddrLoad = CntW'(ADDR_WAIT - 1);
    localparam logic [CntW-1:0] DataLoad = CntW'(DATA_WAIT - 1);
    localparam logic [PtrW:0]   FullCnt  = (PtrW + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StDrive, StWait} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic             prev_q, prev_d;
    logic             ovf_q, ovf_d;
    logic             we_q, we_d;
    logic             addr_q, addr_d;
    logic [7:0]       din_q, din_d;
    logic [8:0]       mem_q [DEPTH];

    logic wr, push, drop, pop;

    assign opl_we   = we_q;
    assign opl_addr = addr_q;
    assign opl_din  = din_q;
    assign full     = (count_q == FullCnt);
    assign level    = count_q;
    assign overflow = ovf_q;
    assign busy     = (count_q != '0) || (state_q != StIdle);

    // Rising-edge write detect, push/drop decision, occupancy and overflow flag.
    always_comb begin
        prev_d  = cpu_cs & cpu_we;
        wr      = cpu_cs & cpu_we & ~prev_q;
        // full is taken before any same-cycle pop, so a write into a full FIFO drops
        push    = wr & ~full;
        drop    = wr & full;
        wptr_d  = push ? wptr_q + PtrW'(1) : wptr_q;
        rptr_d  = pop ? rptr_q + PtrW'(1) : rptr_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (PtrW + 1)'(1);
        end else if (!push && pop) begin
            count_d = count_q - (PtrW + 1)'(1);
        end
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // Replay FSM: pop in idle, hold the strobe, then hold it low for the recovery gap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        din_d   = din_q;
        pop     = 1'b0;
        case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop             = 1'b1;
                    {addr_d, din_d} = mem_q[rptr_q];
                    we_d            = 1'b1;
                    cnt_d           = WeLoad;
                    state_d         = StDrive;
                end
            end
            StDrive: begin
                if (cnt_q == '0) begin
                    we_d    = 1'b0;
                    cnt_d   = addr_q ? DataLoad : AddrLoad;
                    state_d = StWait;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            prev_q  <= 1'b0;
            ovf_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 1'b0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            prev_q  <= prev_d;
            ovf_q   <= ovf_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    // FIFO storage; stale entries are harmless because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= {cpu_addr, cpu_din};
        end
    end

endmodule
